// File: rtl/dm_pipe.sv
// Data memory with a valid/ready request port, configurable load latency and
// alignment/range fault detection. Serves one request at a time.
module dm_pipe #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned LATENCY = 2,
   parameter logic [31:0] BASE    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_exc
);

   localparam int unsigned Depth   = 1 << ADDR_W;
   localparam logic [32:0] Span    = 33'(Depth) << 2;
   localparam logic [1:0]  CntInit = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

   typedef enum logic [2:0] {OpLw, OpLh, OpLhu, OpLb, OpLbu, OpSw, OpSh, OpSb} op_e;
   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        exc_q, exc_d;

   // Contents survive reset; they start out zeroed.
   logic [31:0] mem [Depth] = '{default: '0};

   op_e               op;
   logic [31:0]       offset;
   logic [ADDR_W-1:0] widx;
   logic [31:0]       old_word, merged, load_data;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic              is_store, misaligned, in_range, fault, accept;

   assign op         = op_e'(req_op);
   assign offset     = req_addr - BASE;
   assign widx       = offset[ADDR_W+1:2];
   assign old_word   = mem[widx];
   assign byte_sel   = old_word[{req_addr[1:0], 3'b000} +: 8];
   assign half_sel   = old_word[{req_addr[1], 4'b0000} +: 16];
   assign is_store   = op inside {OpSw, OpSh, OpSb};
   assign misaligned = ((op == OpLw || op == OpSw) && req_addr[1:0] != 2'b00) ||
                       ((op == OpLh || op == OpLhu || op == OpSh) && req_addr[0]);
   assign in_range   = (req_addr >= BASE) && ({1'b0, offset} < Span);
   assign fault      = misaligned || !in_range;
   assign accept     = req_valid && req_ready;

   always_comb begin
      merged = old_word;
      unique case (op)
         OpSw:    merged = req_wdata;
         OpSh:    merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
         OpSb:    merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
         default: ;
      endcase
   end

   always_comb begin
      load_data = '0;
      unique case (op)
         OpLw:    load_data = old_word;
         OpLh:    load_data = {{16{half_sel[15]}}, half_sel};
         OpLhu:   load_data = {16'b0, half_sel};
         OpLb:    load_data = {{24{byte_sel[7]}}, byte_sel};
         OpLbu:   load_data = {24'b0, byte_sel};
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      exc_d   = exc_q;
      unique case (state_q)
         StWait: begin
            if (cnt_q == '0) state_d = StResp;
            else             cnt_d   = cnt_q - 2'd1;
         end
         StResp:  state_d = StIdle;
         default: ;
      endcase
      // A new accept in RESP overrides the return to IDLE.
      if (accept) begin
         exc_d   = fault;
         rdata_d = (fault || is_store) ? '0 : load_data;
         if (!fault && !is_store && LATENCY > 1) begin
            state_d = StWait;
            cnt_d   = CntInit;
         end else begin
            state_d = StResp;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rdata_q <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         exc_q   <= exc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && is_store && !fault) begin
         mem[widx] <= merged;
`ifndef SYNTHESIS
         $display("%d@%h: *%h <= %h", $time, req_pc, req_addr, merged);
`endif
      end
   end

   assign req_ready  = !reset && (state_q != StWait);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign resp_exc   = resp_valid && exc_q;

endmodule

// File: tb/tb_dm_pipe.sv
// Bench for dm_pipe: four instances (LATENCY 1..4, mixed depth/base) under directed
// and random traffic, checked every cycle against a transaction-level model.
module tb_dm_pipe;

   localparam int NL = 4;
   localparam int unsigned LAT [NL] = '{1, 2, 3, 4};
   localparam int unsigned AW  [NL] = '{12, 12, 4, 12};
   localparam logic [31:0] BASES [NL] = '{32'h0, 32'h0, 32'h0000_0400, 32'h8000_0000};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid  [NL];
   logic        req_ready  [NL];
   logic [2:0]  req_op     [NL];
   logic [31:0] req_addr   [NL];
   logic [31:0] req_wdata  [NL];
   logic [31:0] req_pc     [NL];
   logic        resp_valid [NL];
   logic [31:0] resp_rdata [NL];
   logic        resp_exc   [NL];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NL; g++) begin : g_lane
      dm_pipe #(.ADDR_W(AW[g]), .LATENCY(LAT[g]), .BASE(BASES[g])) u_dut (
         .clk        (clk),
         .reset      (reset),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_op     (req_op[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .req_pc     (req_pc[g]),
         .resp_valid (resp_valid[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_exc   (resp_exc[g])
      );
   end

   // ---------------- reference model ----------------
   int          n_pass = 0;
   int          n_total = 0;
   int          due [NL] = '{-1, -1, -1, -1};  // cycles until the response cycle, -1 none
   logic [31:0] m_rdata [NL];
   logic        m_exc [NL];
   logic [31:0] mm [int];
   bit          done = 1'b0;
   int          drv_timeouts = 0;

   function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] w,
                                            input logic [1:0] bl);
      logic [31:0] b, h;
      b = (w >> (8 * bl)) & 32'hFF;
      h = (w >> (16 * bl[1])) & 32'hFFFF;
      case (op)
         3'd0:    return w;
         3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
         3'd2:    return h;
         3'd3:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd4:    return b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [2:0] op, input logic [31:0] old,
                                         input logic [31:0] wd, input logic [1:0] bl);
      logic [31:0] mask, val;
      int sh;
      if (op == 3'd5) return wd;
      if (op == 3'd6) begin
         sh = 16 * bl[1];
         mask = 32'hFFFF << sh;
         val = (wd & 32'hFFFF) << sh;
      end else begin
         sh = 8 * bl;
         mask = 32'hFF << sh;
         val = (wd & 32'hFF) << sh;
      end
      return (old & ~mask) | val;
   endfunction

   function automatic bit is_fault(input int g, input logic [2:0] op, input logic [31:0] a);
      longint av, lo, hi;
      bit mis;
      av  = a;
      lo  = BASES[g];
      hi  = lo + (longint'(4) << AW[g]);
      mis = ((op == 3'd0 || op == 3'd5) && a[1:0] != 2'b00) ||
            ((op == 3'd1 || op == 3'd2 || op == 3'd6) && a[0]);
      return mis || av < lo || av >= hi;
   endfunction

   task automatic check(input string name, input int g, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s lane%0d: got %h, expected %h", name, g, act, exp);
   endtask

   task automatic model_accept(input int g);
      logic [2:0]  op;
      logic [31:0] a, w;
      int k;
      op = req_op[g];
      a  = req_addr[g];
      if (is_fault(g, op, a)) begin
         m_rdata[g] = 32'h0;
         m_exc[g]   = 1'b1;
         due[g]     = 0;
         return;
      end
      k = g * 65536 + int'((a - BASES[g]) >> 2);
      w = mm.exists(k) ? mm[k] : 32'h0;
      m_exc[g] = 1'b0;
      if (op >= 3'd5) begin
         mm[k]      = merge(op, w, req_wdata[g], a[1:0]);
         m_rdata[g] = 32'h0;
         due[g]     = 0;
      end else begin
         m_rdata[g] = load_val(op, w, a[1:0]);
         due[g]     = int'(LAT[g]) - 1;
      end
   endtask

   task automatic step(input int g);
      bit ev, er;
      ev = !reset && due[g] == 0;
      er = !reset && due[g] <= 0;
      check("req_ready", g, 32'(req_ready[g]), 32'(er));
      check("resp_valid", g, 32'(resp_valid[g]), 32'(ev));
      check("resp_rdata", g, resp_rdata[g], ev ? m_rdata[g] : 32'h0);
      check("resp_exc", g, 32'(resp_exc[g]), ev ? 32'(m_exc[g]) : 32'h0);
      if (reset)                       due[g] = -1;
      else if (req_valid[g] && er)     model_accept(g);
      else if (due[g] >= 0)            due[g]--;
   endtask

   // Single compare process: outputs are stable at the falling edge, and the inputs
   // seen here are exactly those the next rising edge will sample.
   always @(negedge clk) begin
      if (done) begin
         check("pin_lb", 0, load_val(3'd3, 32'h1234AB78, 2'd1), 32'hFFFFFFAB);
         check("pin_lbu", 0, load_val(3'd4, 32'h1234AB78, 2'd1), 32'h000000AB);
         check("pin_lh", 0, load_val(3'd1, 32'h8001AB78, 2'd2), 32'hFFFF8001);
         check("pin_lhu", 0, load_val(3'd2, 32'h8001AB78, 2'd2), 32'h00008001);
         check("pin_sb", 0, merge(3'd7, 32'h12345678, 32'hAB, 2'd1), 32'h1234AB78);
         check("pin_sh", 0, merge(3'd6, 32'h1234AB78, 32'h8001, 2'd2), 32'h8001AB78);
         check("pin_mis_lw", 0, 32'(is_fault(0, 3'd0, 32'h13)), 32'h1);
         check("pin_mis_sh", 0, 32'(is_fault(0, 3'd6, 32'h15)), 32'h1);
         check("pin_oor", 0, 32'(is_fault(0, 3'd0, 32'h4000)), 32'h1);
         check("pin_ok", 0, 32'(is_fault(0, 3'd0, 32'h3FFC)), 32'h0);
         check("drv_timeout", 0, 32'(drv_timeouts), 32'h0);
         $display("%0d/%0d checks passed", n_pass, n_total);
         $finish;
      end else begin
         for (int g = 0; g < NL; g++) step(g);
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [2:0]  op;
      logic [31:0] off;
      logic [31:0] wd;
   } dreq_t;

   dreq_t dir [16] = '{
      '{3'd5, 32'h10, 32'h12345678}, '{3'd0, 32'h10, 32'h0},
      '{3'd7, 32'h11, 32'h000000AB}, '{3'd3, 32'h11, 32'h0},
      '{3'd4, 32'h11, 32'h0},        '{3'd0, 32'h10, 32'h0},
      '{3'd6, 32'h12, 32'h00008001}, '{3'd1, 32'h12, 32'h0},
      '{3'd2, 32'h12, 32'h0},        '{3'd0, 32'h10, 32'h0},
      '{3'd0, 32'h13, 32'h0},        '{3'd5, 32'h14, 32'hCAFEF00D},
      '{3'd6, 32'h15, 32'h5555},     '{3'd0, 32'h14, 32'h0},
      '{3'd0, 32'h4000, 32'h0},      '{3'd0, 32'hFFFF_FFFC, 32'h0}
   };

   task automatic issue_all(input logic [2:0] op, input logic [31:0] off, input logic [31:0] wd);
      bit took [NL];
      bit busy;
      for (int g = 0; g < NL; g++) begin
         req_op[g]    = op;
         req_addr[g]  = BASES[g] + off;
         req_wdata[g] = wd;
         req_pc[g]    = $urandom;
         req_valid[g] = 1'b1;
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int g = 0; g < NL; g++) took[g] = req_valid[g] && req_ready[g];
         @(posedge clk);
         #1;
         busy = 1'b0;
         for (int g = 0; g < NL; g++) begin
            if (took[g]) req_valid[g] = 1'b0;
            busy |= req_valid[g];
         end
         if (!busy) return;
      end
      drv_timeouts++;
      for (int g = 0; g < NL; g++) req_valid[g] = 1'b0;
   endtask

   task automatic rand_req(input int g, input bit alt, input bit ld);
      logic [31:0] span, a;
      int kind;
      span = 32'd4 << AW[g];
      kind = int'($urandom_range(9, 0));
      req_valid[g] = 1'b1;
      req_wdata[g] = $urandom;
      req_pc[g]    = $urandom;
      if (alt) begin
         req_op[g]   = ld ? 3'd0 : 3'd5;
         req_addr[g] = BASES[g] + 4 * $urandom_range(3, 0);
         return;
      end
      req_op[g] = 3'($urandom_range(7, 0));
      if (kind < 6)       a = BASES[g] + $urandom_range(63, 0);
      else if (kind < 8)  a = BASES[g] + span - 8 + $urandom_range(15, 0);
      else if (kind == 8) a = BASES[g] - $urandom_range(8, 1);
      else                a = $urandom;
      if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
      req_addr[g] = a;
   endtask

   task automatic run_random(input int cycles, input int pct, input bit alt);
      bit took [NL];
      bit flip [NL];
      for (int g = 0; g < NL; g++) flip[g] = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         for (int g = 0; g < NL; g++) took[g] = req_valid[g] && req_ready[g];
         @(posedge clk);
         #1;
         for (int g = 0; g < NL; g++) begin
            if (!req_valid[g] || took[g]) begin
               if (int'($urandom_range(99, 0)) < pct) begin
                  rand_req(g, alt, flip[g]);
                  flip[g] = !flip[g];
               end else begin
                  req_valid[g] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic idle(input int cycles);
      for (int g = 0; g < NL; g++) req_valid[g] = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int g = 0; g < NL; g++) begin
         req_valid[g] = 1'b0;
         req_op[g]    = 3'd0;
         req_addr[g]  = 32'h0;
         req_wdata[g] = 32'h0;
         req_pc[g]    = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 16; i++) issue_all(dir[i].op, dir[i].off, dir[i].wd);
      idle(6);

      run_random(600, 60, 1'b0);
      idle(6);
      run_random(300, 100, 1'b1);
      idle(6);

      // Reset one cycle after a load is accepted on every lane.
      for (int g = 0; g < NL; g++) begin
         req_op[g]    = 3'd0;
         req_addr[g]  = BASES[g] + 32'h10;
         req_valid[g] = 1'b1;
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < NL; g++) req_valid[g] = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      issue_all(3'd0, 32'h10, 32'h0);
      issue_all(3'd0, 32'h14, 32'h0);

      run_random(600, 100, 1'b0);
      idle(8);
      done = 1'b1;
   end

endmodule
